// File: rtl/cdb_broadcast_arbiter_if.sv
// ----------------------------------------------------------------------------
// cdb_broadcast_arbiter_if
// Bundles the FU result ports and the three common-data-bus lanes.
//   fu_valid/fu_tag/fu_data/fu_rob : FU results, FU i at [i*W +: W]
//   fu_ready                       : per-FU FIFO has room this cycle
//   cdbN_valid/tag/data/rob        : broadcast lanes N = 1..3
// modport master : FU/consumer side (drives results, observes lanes)
// modport slave  : arbiter side
// ----------------------------------------------------------------------------
interface cdb_broadcast_arbiter_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned ROB_W  = 5
);
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU*ROB_W-1:0]  fu_rob;
    logic [NUM_FU-1:0]        fu_ready;

    logic              cdb1_valid;
    logic [TAG_W-1:0]  cdb1_tag;
    logic [DATA_W-1:0] cdb1_data;
    logic [ROB_W-1:0]  cdb1_rob;
    logic              cdb2_valid;
    logic [TAG_W-1:0]  cdb2_tag;
    logic [DATA_W-1:0] cdb2_data;
    logic [ROB_W-1:0]  cdb2_rob;
    logic              cdb3_valid;
    logic [TAG_W-1:0]  cdb3_tag;
    logic [DATA_W-1:0] cdb3_data;
    logic [ROB_W-1:0]  cdb3_rob;

    modport master (
        output fu_valid, fu_tag, fu_data, fu_rob,
        input  fu_ready,
        input  cdb1_valid, cdb1_tag, cdb1_data, cdb1_rob,
        input  cdb2_valid, cdb2_tag, cdb2_data, cdb2_rob,
        input  cdb3_valid, cdb3_tag, cdb3_data, cdb3_rob
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data, fu_rob,
        output fu_ready,
        output cdb1_valid, cdb1_tag, cdb1_data, cdb1_rob,
        output cdb2_valid, cdb2_tag, cdb2_data, cdb2_rob,
        output cdb3_valid, cdb3_tag, cdb3_data, cdb3_rob
    );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_broadcast_arbiter
// Buffers FU results in one FIFO per FU and each cycle grants up to three
// non-empty FIFO heads, scanned round-robin from r_rr_ptr, onto CDB lanes 1..3.
// Lane outputs are registered; ungranted lanes are driven all-zero.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_flush  : synchronous squash of all queued and outgoing results
//   io_bus   : FU result ports, fu_ready and the three CDB lanes (slave)
// ----------------------------------------------------------------------------
module cdb_broadcast_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned ROB_W  = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    cdb_broadcast_arbiter_if.slave        io_bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FU_W  = $clog2(NUM_FU);
    localparam int unsigned LANES = 3;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
    } ent_t;

    ent_t              r_mem    [NUM_FU][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_FU];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_FU];
    logic [CNT_W-1:0]  r_cnt    [NUM_FU];
    logic [FU_W-1:0]   r_rr_ptr;
    logic [LANES-1:0]  r_lane_vld;
    ent_t              r_lane   [LANES];

    logic [NUM_FU-1:0] w_ready;
    logic [NUM_FU-1:0] w_push;
    logic [NUM_FU-1:0] w_pop;
    ent_t              w_in     [NUM_FU];
    logic [FU_W-1:0]   w_rr_nxt;
    logic [LANES-1:0]  w_lane_vld;
    ent_t              w_lane   [LANES];

    // Ready looks only at the registered count: a full FIFO never accepts,
    // even if it is being popped this cycle.
    always_comb begin
        w_ready = '0;
        w_push  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_ready[i] = (r_cnt[i] < CNT_W'(DEPTH));
            w_push[i]  = io_bus.fu_valid[i] & w_ready[i];
            w_in[i]    = '{tag:  io_bus.fu_tag[i*TAG_W +: TAG_W],
                           data: io_bus.fu_data[i*DATA_W +: DATA_W],
                           rob:  io_bus.fu_rob[i*ROB_W +: ROB_W]};
        end
    end

    // Round-robin scan from r_rr_ptr; the n-th non-empty head found goes to lane n.
    always_comb begin
        logic [FU_W-1:0] idx;
        logic [1:0]      n;
        idx        = '0;
        n          = '0;
        w_pop      = '0;
        w_lane_vld = '0;
        w_rr_nxt   = r_rr_ptr;
        for (int l = 0; l < LANES; l++) begin
            w_lane[l] = '0;
        end
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = FU_W'((32'(r_rr_ptr) + k) % NUM_FU);
            if ((r_cnt[idx] != '0) && (n != 2'd3)) begin
                w_pop[idx]    = 1'b1;
                w_lane_vld[n] = 1'b1;
                w_lane[n]     = r_mem[idx][r_rd_ptr[idx]];
                n             = n + 2'd1;
                w_rr_nxt      = (idx == FU_W'(NUM_FU - 1)) ? '0 : idx + FU_W'(1);
            end
        end
    end

    // Control state and registered lanes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_rr_ptr   <= '0;
            r_lane_vld <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_lane[l] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_rr_ptr   <= '0;
            r_lane_vld <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_lane[l] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
            r_rr_ptr   <= w_rr_nxt;
            r_lane_vld <= w_lane_vld;
            for (int l = 0; l < LANES; l++) begin
                r_lane[l] <= w_lane[l];
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by r_cnt.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_push[i] && !i_flush) begin
                r_mem[i][r_wr_ptr[i]] <= w_in[i];
            end
        end
    end

    assign io_bus.fu_ready   = w_ready;
    assign io_bus.cdb1_valid = r_lane_vld[0];
    assign io_bus.cdb1_tag   = r_lane[0].tag;
    assign io_bus.cdb1_data  = r_lane[0].data;
    assign io_bus.cdb1_rob   = r_lane[0].rob;
    assign io_bus.cdb2_valid = r_lane_vld[1];
    assign io_bus.cdb2_tag   = r_lane[1].tag;
    assign io_bus.cdb2_data  = r_lane[1].data;
    assign io_bus.cdb2_rob   = r_lane[1].rob;
    assign io_bus.cdb3_valid = r_lane_vld[2];
    assign io_bus.cdb3_tag   = r_lane[2].tag;
    assign io_bus.cdb3_data  = r_lane[2].data;
    assign io_bus.cdb3_rob   = r_lane[2].rob;
endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_broadcast_arbiter
// Self-checking bench: a queue-based reference model predicts every lane and
// fu_ready each cycle; a vector table and directed sequences add fixed
// expectations for contention, rotation, single result, flush and backpressure.
// ----------------------------------------------------------------------------
module tb_cdb_broadcast_arbiter;
    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 5;
    localparam int ROB_W  = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    cdb_broadcast_arbiter_if #(
        .NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W)
    ) bus ();

    cdb_broadcast_arbiter #(
        .NUM_FU(NUM_FU), .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .io_bus  (bus)
    );

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
    } ent_t;

    typedef struct packed {
        logic v;
        ent_t e;
    } lane_t;

    typedef struct packed {
        logic [3:0]      fv;
        logic [2:0]      exp_v;
        logic [2:0][4:0] exp_tag;  // [0] = lane 1
        logic [3:0]      exp_rdy;
    } vec_t;

    // Reference model state
    ent_t  mq [NUM_FU][$];
    int    m_rr;
    lane_t m_lane [3];
    bit    m_acc [NUM_FU];

    // Driver state
    logic  drv_v [NUM_FU];
    ent_t  drv_e [NUM_FU];
    logic  drv_flush;

    int checks = 0;
    int errors = 0;
    int fu1_low = 0;
    vec_t vec [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fu_valid[i]                  = drv_v[i];
            bus.fu_tag[i*TAG_W +: TAG_W]     = drv_e[i].tag;
            bus.fu_data[i*DATA_W +: DATA_W]  = drv_e[i].data;
            bus.fu_rob[i*ROB_W +: ROB_W]     = drv_e[i].rob;
        end
        flush = drv_flush;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            mq[i].delete();
            m_acc[i] = 1'b0;
        end
        for (int l = 0; l < 3; l++) m_lane[l] = '0;
        m_rr = 0;
    endtask

    // What one clock edge does, stated as queue operations.
    task automatic model_edge();
        int n;
        int last;
        n = 0;
        last = 0;
        for (int i = 0; i < NUM_FU; i++) m_acc[i] = drv_v[i] && (mq[i].size() < DEPTH);
        for (int l = 0; l < 3; l++) m_lane[l] = '0;
        if (drv_flush) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            int f;
            f = (m_rr + k) % NUM_FU;
            if (mq[f].size() > 0 && n < 3) begin
                m_lane[n].v = 1'b1;
                m_lane[n].e = mq[f].pop_front();
                n++;
                last = f;
            end
        end
        if (n > 0) m_rr = (last + 1) % NUM_FU;
        for (int i = 0; i < NUM_FU; i++) if (m_acc[i]) mq[i].push_back(drv_e[i]);
    endtask

    task automatic compare_lanes();
        lane_t act [3];
        act[0] = {bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_data, bus.cdb1_rob};
        act[1] = {bus.cdb2_valid, bus.cdb2_tag, bus.cdb2_data, bus.cdb2_rob};
        act[2] = {bus.cdb3_valid, bus.cdb3_tag, bus.cdb3_data, bus.cdb3_rob};
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("model_lane%0d", l + 1), 128'(act[l]), 128'(m_lane[l]));
        end
    endtask

    task automatic compare_all();
        logic [NUM_FU-1:0] rdy;
        compare_lanes();
        for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[i].size() < DEPTH);
        chk("model_fu_ready", 128'(bus.fu_ready), 128'(rdy));
    endtask

    task automatic step();
        drive();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_drv();
        for (int i = 0; i < NUM_FU; i++) begin
            drv_v[i] = 1'b0;
            drv_e[i] = '0;
        end
        drv_flush = 1'b0;
    endtask

    // FUs hold an unaccepted result and retry; flush discards it.
    task automatic next_drv(input int pct, input bit allow_flush);
        for (int i = 0; i < NUM_FU; i++) begin
            if (!(drv_v[i] && !m_acc[i] && !drv_flush)) begin
                drv_v[i] = ($urandom_range(99) < pct);
                drv_e[i] = '{tag: 5'($urandom), data: {$urandom, $urandom}, rob: 5'($urandom)};
            end
        end
        drv_flush = allow_flush && ($urandom_range(39) == 0);
    endtask

    function automatic logic [2:0] dut_valids();
        return {bus.cdb3_valid, bus.cdb2_valid, bus.cdb1_valid};
    endfunction

    initial begin
        // Rows applied from a fresh reset; tag pushed by FU i in row r is r*4+i.
        vec[0] = '{fv: 4'b1111, exp_v: 3'b000, exp_tag: {5'd0,  5'd0,  5'd0},  exp_rdy: 4'b1111};
        vec[1] = '{fv: 4'b0000, exp_v: 3'b111, exp_tag: {5'd2,  5'd1,  5'd0},  exp_rdy: 4'b1111};
        vec[2] = '{fv: 4'b0000, exp_v: 3'b001, exp_tag: {5'd0,  5'd0,  5'd3},  exp_rdy: 4'b1111};
        vec[3] = '{fv: 4'b1111, exp_v: 3'b000, exp_tag: {5'd0,  5'd0,  5'd0},  exp_rdy: 4'b1111};
        vec[4] = '{fv: 4'b1111, exp_v: 3'b111, exp_tag: {5'd14, 5'd13, 5'd12}, exp_rdy: 4'b0111};
        vec[5] = '{fv: 4'b1111, exp_v: 3'b111, exp_tag: {5'd17, 5'd16, 5'd15}, exp_rdy: 4'b1011};
        vec[6] = '{fv: 4'b0000, exp_v: 3'b111, exp_tag: {5'd20, 5'd19, 5'd18}, exp_rdy: 4'b1111};
        vec[7] = '{fv: 4'b0000, exp_v: 3'b011, exp_tag: {5'd0,  5'd22, 5'd21}, exp_rdy: 4'b1111};

        // Reset
        rst_n = 1'b0;
        idle_drv();
        drive();
        model_reset();
        #1;
        compare_lanes();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        compare_all();
        chk("reset_ready", 128'(bus.fu_ready), 128'(4'b1111));
        chk("reset_valid", 128'(dut_valids()), 128'(3'b000));

        // Contention and rotation table
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                drv_v[i] = vec[r].fv[i];
                drv_e[i] = '{tag: 5'(r * 4 + i), data: 64'(r * 4 + i), rob: 5'(i)};
            end
            drv_flush = 1'b0;
            step();
            chk($sformatf("tbl%0d_valid", r), 128'(dut_valids()), 128'(vec[r].exp_v));
            chk($sformatf("tbl%0d_tags", r),
                128'({bus.cdb3_tag, bus.cdb2_tag, bus.cdb1_tag}), 128'(vec[r].exp_tag));
            chk($sformatf("tbl%0d_ready", r), 128'(bus.fu_ready), 128'(vec[r].exp_rdy));
        end

        // Single result: two edges of latency, one-cycle pulse
        idle_drv();
        step();
        drv_v[2] = 1'b1;
        drv_e[2] = '{tag: 5'd7, data: 64'hDEAD_BEEF, rob: 5'd3};
        step();
        chk("single_not_early", 128'(bus.cdb1_valid), 128'(1'b0));
        idle_drv();
        step();
        chk("single_lane1",
            128'({bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_data, bus.cdb1_rob}),
            128'({1'b1, 5'd7, 64'hDEAD_BEEF, 5'd3}));
        chk("single_lane23",
            128'({bus.cdb2_valid, bus.cdb2_tag, bus.cdb2_data, bus.cdb2_rob,
                  bus.cdb3_valid, bus.cdb3_tag, bus.cdb3_data, bus.cdb3_rob}), 128'(0));
        step();
        chk("single_pulse", 128'(bus.cdb1_valid), 128'(1'b0));

        // Flush with five results queued and a same-edge push on FU0
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                drv_v[i] = 1'b1;
                drv_e[i] = '{tag: 5'(8 + p * 4 + i), data: 64'(100 + p * 4 + i), rob: 5'(i)};
            end
            step();
        end
        idle_drv();
        drv_v[0] = 1'b1;
        drv_e[0] = '{tag: 5'd30, data: 64'h55, rob: 5'd1};
        drv_flush = 1'b1;
        step();
        chk("flush_valid", 128'(dut_valids()), 128'(3'b000));
        chk("flush_ready", 128'(bus.fu_ready), 128'(4'b1111));
        idle_drv();
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("flush_drain%0d", c), 128'(dut_valids()), 128'(3'b000));
        end
        for (int i = 0; i < NUM_FU; i++) begin
            drv_v[i] = 1'b1;
            drv_e[i] = '{tag: 5'(24 + i), data: 64'(24 + i), rob: 5'(i)};
        end
        step();
        idle_drv();
        step();
        chk("flush_rr_valid", 128'(dut_valids()), 128'(3'b111));
        chk("flush_rr_tags", 128'({bus.cdb3_tag, bus.cdb2_tag, bus.cdb1_tag}),
            128'({5'd26, 5'd25, 5'd24}));
        step();
        chk("flush_rr_tail", 128'({dut_valids(), bus.cdb1_tag}), 128'({3'b001, 5'd27}));

        // Saturating load: every FU pushes and retries each cycle
        idle_drv();
        for (int c = 0; c < 40; c++) begin
            next_drv(100, 1'b0);
            step();
            if (!bus.fu_ready[1]) fu1_low++;
        end
        chk("fu1_backpressure_seen", 128'(fu1_low > 0), 128'(1'b1));

        // Random traffic with occasional flush and one asynchronous reset
        for (int c = 0; c < 500; c++) begin
            next_drv(55, 1'b1);
            step();
            if (c == 250) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_lanes();
                idle_drv();
                drive();
                @(posedge clk);
                #1;
                compare_lanes();
                rst_n = 1'b1;
            end
        end

        idle_drv();
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
